escritor_ram: RTL and testbench

ESCRITOR_RAM -- requirements
Module: escritor_ram

---
 rtl/escritor_ram.sv | 153 +++++++++++++++
 tb/tb_escritor_ram.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/escritor_ram.sv
// Byte-pair to RAM word writer: packs two bytes (low first) into a 16-bit word and writes it at consecutive even addresses.
// Latency: a word is presented on escribir the cycle after its high byte is accepted; the address advances the cycle after ack.
// Backpressure: dato_listo drops while a write is pending; a write waits up to TIMEOUT cycles for ack before the load aborts with error.
module escritor_ram #(
  parameter logic [25:0] ADDR_MAX = 26'h2AE5EE0,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iniciar,
  input  logic        cancelar,
  input  logic [7:0]  dato_in,
  input  logic        dato_valido,
  output logic        dato_listo,
  output logic [25:0] DireccionRAM,
  output logic [15:0] DatoRAM,
  output logic        escribir,
  input  logic        ack,
  output logic        ocupado,
  output logic        terminado,
  output logic        error
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    REPOSO    = 3'd0,
    BYTE_BAJO = 3'd1,
    BYTE_ALTO = 3'd2,
    ESCRIBE   = 3'd3,
    FIN       = 3'd4
  } estado_t;

  estado_t         r_state;
  estado_t         w_next;
  logic [25:0]     r_addr;
  logic [15:0]     r_dat;
  logic [CW-1:0]   r_cnt;
  logic            r_terminado;
  logic            r_error;
  logic            w_last_addr;
  logic            w_timeout;

  // The last word of the load is the one written at ADDR_MAX.
  assign w_last_addr = (r_addr == ADDR_MAX);
  // Final ack-less cycle: the counter is about to reach TIMEOUT.
  assign w_timeout   = !ack && (r_cnt == CW'(TIMEOUT - 1));

  // State register; reset forces REPOSO so escribir drops without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= REPOSO;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decision; cancelar overrides every other input.
  always_comb begin
    w_next = r_state;
    if (cancelar) begin
      w_next = REPOSO;
    end else begin
      case (r_state)
        REPOSO, FIN: if (iniciar)     w_next = BYTE_BAJO;
        BYTE_BAJO:   if (dato_valido) w_next = BYTE_ALTO;
        BYTE_ALTO:   if (dato_valido) w_next = ESCRIBE;
        ESCRIBE: begin
          if (ack) begin
            w_next = w_last_addr ? FIN : BYTE_BAJO;
          end else if (w_timeout) begin
            w_next = FIN;
          end
        end
        default:     w_next = REPOSO;
      endcase
    end
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    dato_listo = 1'b0;
    escribir   = 1'b0;
    ocupado    = 1'b0;
    case (r_state)
      BYTE_BAJO, BYTE_ALTO: begin
        dato_listo = 1'b1;
        ocupado    = 1'b1;
      end
      ESCRIBE: begin
        escribir = 1'b1;
        ocupado  = 1'b1;
      end
      default: ;
    endcase
  end

  // Address, data word, ack wait counter and sticky completion flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_dat       <= '0;
      r_cnt       <= '0;
      r_terminado <= 1'b0;
      r_error     <= 1'b0;
    end else if (cancelar) begin
      r_terminado <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        REPOSO, FIN: begin
          if (iniciar) begin
            r_addr      <= '0;
            r_terminado <= 1'b0;
            r_error     <= 1'b0;
          end
        end
        BYTE_BAJO: begin
          if (dato_valido) r_dat[7:0] <= dato_in;
        end
        BYTE_ALTO: begin
          if (dato_valido) begin
            r_dat[15:8] <= dato_in;
            r_cnt       <= '0;
          end
        end
        ESCRIBE: begin
          if (ack) begin
            // The address is held on the final word so it never passes ADDR_MAX.
            if (w_last_addr) begin
              r_terminado <= 1'b1;
            end else begin
              r_addr <= r_addr + 26'd2;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_timeout) begin
              r_terminado <= 1'b1;
              r_error     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign DireccionRAM = r_addr;
  assign DatoRAM      = r_dat;
  assign terminado    = r_terminado;
  assign error        = r_error;

endmodule

// File: tb/tb_escritor_ram.sv
module tb_escritor_ram;

  localparam logic [25:0] AMAX = 26'd4;
  localparam int          TO   = 8;

  logic        clk;
  logic        rst_n;
  logic        iniciar;
  logic        cancelar;
  logic [7:0]  dato_in;
  logic        dato_valido;
  logic        dato_listo;
  logic [25:0] DireccionRAM;
  logic [15:0] DatoRAM;
  logic        escribir;
  logic        ack;
  logic        ocupado;
  logic        terminado;
  logic        error;

  int n_checks = 0;
  int n_err    = 0;

  escritor_ram #(.ADDR_MAX(AMAX), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .cancelar(cancelar),
    .dato_in(dato_in), .dato_valido(dato_valido), .dato_listo(dato_listo),
    .DireccionRAM(DireccionRAM), .DatoRAM(DatoRAM), .escribir(escribir),
    .ack(ack), .ocupado(ocupado), .terminado(terminado), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A load is "busy" while collecting bytes or writing; the word being built
  // has a low half once m_hi is set; m_wr marks a pending write.
  logic        m_busy, m_hi, m_wr, m_done, m_err;
  int          m_wait;
  logic [25:0] m_addr;
  logic [15:0] m_dat;
  logic [41:0] model_log[$];
  logic [41:0] dut_log[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_hi <= 0; m_wr <= 0; m_done <= 0; m_err <= 0;
      m_wait <= 0; m_addr <= '0; m_dat <= '0;
    end else if (cancelar) begin
      m_busy <= 0; m_hi <= 0; m_wr <= 0; m_done <= 0; m_err <= 0;
    end else if (!m_busy) begin
      if (iniciar) begin
        m_busy <= 1; m_hi <= 0; m_addr <= '0; m_done <= 0; m_err <= 0;
      end
    end else if (!m_wr) begin
      if (dato_valido) begin
        if (!m_hi) begin
          m_dat[7:0] <= dato_in;
          m_hi       <= 1;
        end else begin
          m_dat[15:8] <= dato_in;
          m_hi        <= 0;
          m_wr        <= 1;
          m_wait      <= 0;
        end
      end
    end else if (ack) begin
      model_log.push_back({m_addr, m_dat});
      m_wr <= 0;
      if (m_addr == AMAX) begin
        m_busy <= 0;
        m_done <= 1;
      end else begin
        m_addr <= m_addr + 26'd2;
      end
    end else if (m_wait + 1 == TO) begin
      m_wr <= 0; m_busy <= 0; m_done <= 1; m_err <= 1;
    end else begin
      m_wait <= m_wait + 1;
    end
  end

  // Every cycle, away from the active edge, DUT outputs must match the model.
  always @(negedge clk) begin
    chk("escribir",     32'(escribir),     32'(m_wr));
    chk("dato_listo",   32'(dato_listo),   32'(m_busy && !m_wr));
    chk("ocupado",      32'(ocupado),      32'(m_busy));
    chk("terminado",    32'(terminado),    32'(m_done));
    chk("error",        32'(error),        32'(m_err));
    chk("DireccionRAM", 32'(DireccionRAM), 32'(m_addr));
    chk("DatoRAM",      32'(DatoRAM),      32'(m_dat));
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_iniciar();
    @(negedge clk); iniciar = 1'b1;
    @(negedge clk); iniciar = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    @(negedge clk);
    dato_in = b;
    dato_valido = 1'b1;
    k = 0;
    while (!dato_listo && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("send_byte_timeout", 32'(k), 32'd0);
    @(negedge clk);
    dato_valido = 1'b0;
  endtask

  task automatic wait_escribir();
    int k;
    k = 0;
    while (!escribir && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("wait_escribir_timeout", 32'(k), 32'd0);
  endtask

  // Acks the pending write after d ack-less cycles; reports cycles seen with escribir=1.
  task automatic do_write(input int d, output int hi);
    wait_escribir();
    dut_log.push_back({DireccionRAM, DatoRAM});
    hi = escribir ? 1 : 0;
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      if (escribir) hi++;
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    int hi;
    int k;
    rst_n = 1'b1; iniciar = 0; cancelar = 0; dato_in = '0; dato_valido = 0; ack = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_escribir", 32'(escribir), 0);
    chk("rst_ocupado", 32'(ocupado), 0);
    chk("rst_addr", 32'(DireccionRAM), 0);
    chk("rst_dato", 32'(DatoRAM), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // dato_valido while idle changes nothing
    @(negedge clk); dato_in = 8'hA5; dato_valido = 1'b1;
    repeat (3) @(negedge clk);
    dato_valido = 1'b0;
    chk("idle_valid_dato", 32'(DatoRAM), 0);
    chk("idle_valid_ocupado", 32'(ocupado), 0);

    // Full load of three words; the middle ack is delayed 5 cycles
    pulse_iniciar();
    send_byte(8'h34); send_byte(8'h12);
    do_write(0, hi);
    send_byte(8'h78); send_byte(8'h56);
    do_write(5, hi);
    chk("delay5_escribir_cycles", 32'(hi), 32'd6);
    send_byte(8'hBC);
    pulse_iniciar();
    chk("iniciar_in_alto_addr", 32'(DireccionRAM), 32'd4);
    chk("iniciar_in_alto_listo", 32'(dato_listo), 1);
    send_byte(8'h9A);
    do_write(0, hi);
    chk("end_terminado", 32'(terminado), 1);
    chk("end_ocupado", 32'(ocupado), 0);
    chk("end_listo", 32'(dato_listo), 0);
    chk("end_error", 32'(error), 0);
    chk("end_addr", 32'(DireccionRAM), 32'd4);
    chk("dut_log_size", 32'(dut_log.size()), 3);
    chk("model_log_size", 32'(model_log.size()), 3);
    if (dut_log.size() >= 3 && model_log.size() >= 3) begin
      chk("dut_w0", 32'(dut_log[0]),   32'({26'd0, 16'h1234}));
      chk("dut_w1", 32'(dut_log[1]),   32'({26'd2, 16'h5678}));
      chk("dut_w2", 32'(dut_log[2]),   32'({26'd4, 16'h9ABC}));
      chk("model_w0", 32'(model_log[0]), 32'({26'd0, 16'h1234}));
      chk("model_w2", 32'(model_log[2]), 32'({26'd4, 16'h9ABC}));
    end

    // Ack timeout
    pulse_iniciar();
    chk("restart_addr", 32'(DireccionRAM), 0);
    chk("restart_terminado", 32'(terminado), 0);
    send_byte(8'h11); send_byte(8'h22);
    wait_escribir();
    k = 0;
    while (escribir && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_cycles", 32'(k), 32'(TO));
    chk("timeout_error", 32'(error), 1);
    chk("timeout_terminado", 32'(terminado), 1);
    chk("timeout_escribir", 32'(escribir), 0);

    // cancelar together with ack at address 2
    pulse_iniciar();
    chk("iniciar_clears_error", 32'(error), 0);
    send_byte(8'h01); send_byte(8'h02);
    do_write(0, hi);
    send_byte(8'h03); send_byte(8'h04);
    wait_escribir();
    ack = 1'b1; cancelar = 1'b1;
    @(negedge clk);
    ack = 1'b0; cancelar = 1'b0;
    chk("cancel_ocupado", 32'(ocupado), 0);
    chk("cancel_escribir", 32'(escribir), 0);
    chk("cancel_addr", 32'(DireccionRAM), 32'd2);
    chk("cancel_terminado", 32'(terminado), 0);

    // Reset in the middle of a write at address 2
    pulse_iniciar();
    send_byte(8'h05); send_byte(8'h06);
    do_write(0, hi);
    send_byte(8'h07); send_byte(8'h08);
    wait_escribir();
    chk("pre_reset_addr", 32'(DireccionRAM), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_escribir", 32'(escribir), 0);
    chk("async_rst_addr", 32'(DireccionRAM), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", 32'(ocupado), 0);
    pulse_iniciar();
    send_byte(8'h09); send_byte(8'h0A);
    wait_escribir();
    chk("post_reset_first_addr", 32'(DireccionRAM), 0);
    chk("post_reset_first_dato", 32'(DatoRAM), 32'h0A09);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      iniciar     = ($urandom_range(0, 9) == 0);
      cancelar    = ($urandom_range(0, 59) == 0);
      dato_valido = $urandom_range(0, 1) != 0;
      dato_in     = 8'($urandom);
      ack         = ($urandom_range(0, 9) < 3);
    end
    @(negedge clk);
    iniciar = 0; cancelar = 0; dato_valido = 0; ack = 0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
